// File: rtl/sram_like_to_sram.sv
// sram_like_to_sram: responder end of the sram-like protocol.
// Takes one request at a time and drives a single-port synchronous SRAM
// with one-cycle read latency. WAIT_CYCLES stretches the response so
// callers can exercise stall paths.
module sram_like_to_sram #(
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        sl_req,
   input  logic        sl_wr,
   input  logic [1:0]  sl_size,
   input  logic [31:0] sl_addr,
   input  logic [31:0] sl_wdata,
   output logic        sl_addr_ok,
   output logic        sl_data_ok,
   output logic [31:0] sl_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCESS, S_CAPTURE, S_WAIT, S_RESP
   } state_t;

   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   state_t      state_q;
   logic        wr_q;
   logic [3:0]  cnt_q;
   logic        ram_en_q;
   logic [3:0]  ram_we_q;
   logic [31:0] ram_addr_q;
   logic [31:0] ram_wdata_q;
   logic        data_ok_q;
   logic [31:0] rdata_q;
   logic        accept;

   // Byte-lane mask for a write; misaligned accesses get an empty mask so
   // they complete without touching memory.
   function automatic logic [3:0] wmask(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         2'd0:    m = 4'b0001 << a;
         2'd1:    m = a[0] ? 4'b0000 : (a[1] ? 4'b1100 : 4'b0011);
         default: m = (a != 2'b00) ? 4'b0000 : 4'b1111;
      endcase
      return m;
   endfunction

   // A new request can land while idle or while the previous one is
   // reporting completion, which gives back-to-back throughput.
   assign sl_addr_ok = (state_q == S_IDLE) || (state_q == S_RESP);
   assign accept     = sl_req & sl_addr_ok;

   // Transaction FSM; all SRAM and response outputs are registered here so
   // reset clears them asynchronously.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q     <= S_IDLE;
         wr_q        <= 1'b0;
         cnt_q       <= 4'd0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 4'd0;
         ram_addr_q  <= 32'd0;
         ram_wdata_q <= 32'd0;
         data_ok_q   <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         ram_en_q  <= 1'b0;
         ram_we_q  <= 4'd0;
         data_ok_q <= 1'b0;
         case (state_q)
            S_IDLE, S_RESP: begin
               if (accept) begin
                  state_q     <= S_ACCESS;
                  wr_q        <= sl_wr;
                  ram_en_q    <= 1'b1;
                  ram_we_q    <= sl_wr ? wmask(sl_size, sl_addr[1:0]) : 4'd0;
                  ram_addr_q  <= {sl_addr[31:2], 2'b00};
                  ram_wdata_q <= sl_wdata;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ACCESS: state_q <= S_CAPTURE;
            S_CAPTURE: begin
               if (!wr_q) rdata_q <= ram_rdata;
               cnt_q <= WAIT_N;
               if (WAIT_N != 4'd0) begin
                  state_q <= S_WAIT;
               end else begin
                  state_q   <= S_RESP;
                  data_ok_q <= 1'b1;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q   <= S_RESP;
                  data_ok_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign sl_data_ok = data_ok_q;
   assign sl_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_to_sram.sv
// Bench for sram_like_to_sram: a zero-wait and a five-wait instance, each
// with its own SRAM model; read expectations go through a scoreboard queue.
module tb_sram_like_to_sram;

   logic        clk = 1'b0;
   logic        areset;
   logic        sel;          // 0 -> zero-wait instance, 1 -> five-wait instance
   logic        req, wr;
   logic [1:0]  sz;
   logic [31:0] addr, wdata;

   logic        aok0, dok0, en0, aok5, dok5, en5;
   logic [31:0] rd0, ra0, wd0, mrd0, rd5, ra5, wd5, mrd5;
   logic [3:0]  we0, we5;

   logic [31:0] mem0 [0:255];
   logic [31:0] mem5 [0:255];

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   sram_like_to_sram #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .areset(areset), .sl_req(req & ~sel), .sl_wr(wr), .sl_size(sz),
      .sl_addr(addr), .sl_wdata(wdata), .sl_addr_ok(aok0), .sl_data_ok(dok0),
      .sl_rdata(rd0), .ram_en(en0), .ram_we(we0), .ram_addr(ra0),
      .ram_wdata(wd0), .ram_rdata(mrd0));

   sram_like_to_sram #(.WAIT_CYCLES(5)) u5 (
      .clk(clk), .areset(areset), .sl_req(req & sel), .sl_wr(wr), .sl_size(sz),
      .sl_addr(addr), .sl_wdata(wdata), .sl_addr_ok(aok5), .sl_data_ok(dok5),
      .sl_rdata(rd5), .ram_en(en5), .ram_we(we5), .ram_addr(ra5),
      .ram_wdata(wd5), .ram_rdata(mrd5));

   // Block-RAM models: one-cycle read latency, per-byte writes.
   always @(posedge clk) begin
      if (en0) begin
         mrd0 <= mem0[ra0[9:2]];
         for (int b = 0; b < 4; b++) if (we0[b]) mem0[ra0[9:2]][b*8 +: 8] <= wd0[b*8 +: 8];
      end
      if (en5) begin
         mrd5 <= mem5[ra5[9:2]];
         for (int b = 0; b < 4; b++) if (we5[b]) mem5[ra5[9:2]][b*8 +: 8] <= wd5[b*8 +: 8];
      end
   end

   logic        o_aok, o_dok, o_en;
   logic [31:0] o_rd, o_ra, o_wd;
   logic [3:0]  o_we;
   assign o_aok = sel ? aok5 : aok0;
   assign o_dok = sel ? dok5 : dok0;
   assign o_en  = sel ? en5  : en0;
   assign o_we  = sel ? we5  : we0;
   assign o_rd  = sel ? rd5  : rd0;
   assign o_ra  = sel ? ra5  : ra0;
   assign o_wd  = sel ? wd5  : wd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on the selected instance, checking the SRAM-side
   // strobe, completion latency, addr_ok during the busy window and read data.
   task automatic xact(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ewe, input logic [31:0] erd);
      int   lat;
      int   wc;
      logic aok_low;
      wc = sel ? 5 : 0;
      @(negedge clk);
      req = 1'b1; wr = w; sz = s; addr = a; wdata = wd;
      if (!w) exp_q.push_back(erd);
      #1 chk("addr_ok_when_idle", {31'd0, o_aok}, 32'd1);
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("ram_en_access", {31'd0, o_en}, 32'd1);
      chk("ram_we_access", {28'd0, o_we}, {28'd0, ewe});
      chk("ram_addr_access", o_ra, {a[31:2], 2'b00});
      if (w) chk("ram_wdata_access", o_wd, wd);
      lat = 1;
      aok_low = 1'b1;
      while (!o_dok && lat < 30) begin
         aok_low &= ~o_aok;
         @(negedge clk);
         lat++;
      end
      chk("data_ok_latency", 32'(lat), 32'(3 + wc));
      chk("addr_ok_low_busy", {31'd0, aok_low}, 32'd1);
      if (o_dok && !w && exp_q.size() > 0) chk("read_data", o_rd, exp_q.pop_front());
      @(negedge clk);
      chk("data_ok_single_pulse", {31'd0, o_dok}, 32'd0);
   endtask

   initial begin
      int n;
      logic seen;
      areset = 1'b1; sel = 1'b0; req = 1'b0; wr = 1'b0; sz = 2'd0;
      addr = 32'd0; wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ram_en", {31'd0, en0}, 32'd0);
      chk("reset_data_ok", {31'd0, dok0}, 32'd0);
      chk("reset_rdata", rd0, 32'd0);
      chk("reset_ram_addr", ra0, 32'd0);
      areset = 1'b0;
      #1 chk("addr_ok_after_reset", {31'd0, aok0}, 32'd1);

      // zero-wait instance: full-width, partial, misaligned accesses
      xact(1, 2'd2, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0);
      xact(0, 2'd2, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF);
      xact(1, 2'd0, 32'h103, 32'h44000000, 4'b1000, 32'h0);
      xact(1, 2'd1, 32'h102, 32'h44330000, 4'b1100, 32'h0);
      xact(0, 2'd2, 32'h100, 32'h0,        4'b0000, 32'h4433BEEF);
      xact(1, 2'd2, 32'h101, 32'h12345678, 4'b0000, 32'h0);
      xact(0, 2'd2, 32'h100, 32'h0,        4'b0000, 32'h4433BEEF);
      xact(1, 2'd0, 32'h101, 32'h0000AA00, 4'b0010, 32'h0);
      xact(1, 2'd1, 32'h101, 32'h55555555, 4'b0000, 32'h0);
      xact(1, 2'd3, 32'h104, 32'h0BADF00D, 4'b1111, 32'h0);
      xact(0, 2'd2, 32'h102, 32'h0,        4'b0000, 32'h4433AAEF);
      xact(0, 2'd0, 32'h105, 32'h0,        4'b0000, 32'h0BADF00D);

      // back-to-back: write held, read queued up for the RESP cycle
      @(negedge clk);
      req = 1'b1; wr = 1'b1; sz = 2'd2; addr = 32'h200; wdata = 32'h11111111;
      @(posedge clk); #1;
      wr = 1'b0; addr = 32'h200; wdata = 32'h0;
      exp_q.push_back(32'h11111111);
      @(negedge clk);
      chk("b2b_addr_ok_access", {31'd0, aok0}, 32'd0);
      @(negedge clk);
      chk("b2b_addr_ok_capture", {31'd0, aok0}, 32'd0);
      chk("b2b_no_reaccess", {31'd0, en0}, 32'd0);
      @(negedge clk);
      chk("b2b_data_ok_resp", {31'd0, dok0}, 32'd1);
      chk("b2b_addr_ok_resp", {31'd0, aok0}, 32'd1);
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("b2b_second_ram_en", {31'd0, en0}, 32'd1);
      chk("b2b_second_we", {28'd0, we0}, 32'd0);
      chk("b2b_second_addr", ra0, 32'h200);
      n = 1;
      while (!dok0 && n < 30) begin @(negedge clk); n++; end
      chk("b2b_second_latency", 32'(n), 32'd3);
      if (dok0 && exp_q.size() > 0) chk("b2b_read_data", rd0, exp_q.pop_front());

      // five-wait instance
      sel = 1'b1;
      xact(1, 2'd2, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h0);
      xact(0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'hCAFEF00D);

      // reset while the read sits in WAIT
      @(negedge clk);
      req = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'h40;
      @(posedge clk); #1 req = 1'b0;
      repeat (4) @(negedge clk);
      areset = 1'b1;
      #1;
      chk("rst_wait_data_ok", {31'd0, dok5}, 32'd0);
      chk("rst_wait_ram_en", {31'd0, en5}, 32'd0);
      chk("rst_wait_rdata", rd5, 32'd0);
      chk("rst_wait_ram_addr", ra5, 32'd0);
      repeat (2) @(negedge clk);
      areset = 1'b0;
      #1 chk("rst_wait_addr_ok", {31'd0, aok5}, 32'd1);
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= dok5; end
      chk("rst_wait_no_data_ok", {31'd0, seen}, 32'd0);
      xact(0, 2'd2, 32'h40, 32'h0, 4'b0000, 32'hCAFEF00D);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_like_to_sram.md
# sram_like_to_sram

Responder end of the sram-like protocol: accepts one sram-like request at a time and drives a synchronous single-port SRAM (block RAM, one-cycle read latency). It returns `sl_addr_ok`/`sl_data_ok` with read data. It sits behind the CPU-side sram-to-sram-like bridges as the memory model for instruction/data ports. A configurable number of wait states lets the bench and the SoC exercise pipeline stalls.

## Interface
- `WAIT_CYCLES`, default 0: extra cycles inserted between SRAM data capture and `sl_data_ok`. Legal range 0..15.
- `clk`  in  1  clock; everything is on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `sl_req`  in  1  request valid.
- `sl_wr`  in  1  1 = write, 0 = read.
- `sl_size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
- `sl_addr`  in  32  byte address.
- `sl_wdata`  in  32  write data, lane-aligned by requester.
- `sl_addr_ok`  out  1  request accepted this cycle when high together with `sl_req`.
- `sl_data_ok`  out  1  one-cycle pulse marking transaction completion.
- `sl_rdata`  out  32  read data, valid while `sl_data_ok` is high.
- `ram_en`  out  1  SRAM access strobe.
- `ram_we`  out  4  SRAM byte write enables.
- `ram_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `ram_wdata`  out  32  SRAM write data.
- `ram_rdata`  in  32  SRAM read data, valid the cycle after `ram_en`.

## Operation
- States: IDLE, ACCESS, CAPTURE, WAIT, RESP. A 4-bit wait counter is used in WAIT.
- `sl_addr_ok` is combinational: high in IDLE and RESP, low otherwise.
- **Accept:** `sl_req & sl_addr_ok` registers `wr`, `size`, `addr` and `wdata`, then moves to ACCESS. In any other state `sl_req` is ignored.
- **ACCESS (1 cycle):**
  - `ram_en` = 1.
  - `ram_addr` and `ram_wdata` come from the latched request.
  - `ram_we` = 0 for reads; for writes it is the decoded mask.
  - Next state is CAPTURE.
- **Write mask decode:**
  - size 0: `4'b0001 << addr[1:0]`.
  - size 1: `addr[1] ? 4'b1100 : 4'b0011`.
  - size 2 or 3: `4'b1111`.
- **Misaligned requests** (size 1 with `addr[0]` set; size 2/3 with `addr[1:0]` ≠ 0):
  - Still accepted and completed normally.
  - `ram_we` is forced to 0, so no write occurs.
  - `sl_rdata` returns the aligned word.
- **CAPTURE (1 cycle):**
  - `ram_rdata` is registered into the read-data register on reads; writes leave it unchanged.
  - Counter is loaded with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, else RESP.
- **WAIT:** counter decrements each cycle; exits to RESP in the cycle it reaches 1.
- **RESP (1 cycle):**
  - `sl_data_ok` = 1; `sl_rdata` = read-data register.
  - A new request accepted in the same cycle goes to ACCESS; otherwise next state is IDLE.
- **Outputs outside these states:**
  - `ram_en` and `ram_we` are 0 outside ACCESS.
  - `ram_addr` and `ram_wdata` hold their last values.
  - `sl_rdata` holds until the next read's CAPTURE.
- Read data is returned full-word and unshifted; byte/halfword extraction is the requester's job.

## Timing
- Reset value of every output is 0; state is IDLE. `sl_addr_ok` = 1 immediately after reset deasserts.
- With the request accepted in cycle T:
  - `ram_en` is high in T+1.
  - `ram_rdata` is sampled in T+2.
  - `sl_data_ok` is high in T+3+`WAIT_CYCLES`.
- Back-to-back throughput: one transaction per 3+`WAIT_CYCLES` cycles. A request accepted during RESP sees `ram_en` in the next cycle.
- `sl_addr_ok` and `sl_data_ok` may be high in the same cycle (RESP). `sl_data_ok` belongs to the old transaction; `sl_addr_ok` belongs to the new one.
- Never more than one transaction outstanding, and never two `sl_data_ok` pulses per request.
- **Reset mid-transaction** (any state):
  - The transaction is aborted and no `sl_data_ok` is issued.
  - `ram_en`/`ram_we` drop immediately (asynchronously).
  - A write aborted before ACCESS never reaches the SRAM.
- `sl_req` held high after acceptance is not re-accepted until IDLE or RESP. The requester must drop or change it after `sl_addr_ok`.

## Test plan
- **Word write then read**, `WAIT_CYCLES`=0: write `0xDEADBEEF` to `0x100` (accepted at T) gives `ram_we`=`4'b1111`, `ram_addr`=`0x100` in T+1 and `sl_data_ok` at T+3. The following read of `0x100` returns `sl_rdata`=`0xDEADBEEF` with `sl_data_ok` 3 cycles after accept.
- **Byte/halfword writes:**
  - sb to `0x103` with `sl_wdata`=`0x44000000` gives `ram_we`=`4'b1000`.
  - sh to `0x102` gives `4'b1100`.
  - A word read then returns the merged value, e.g. `0x4433BEEF` after writing `0x44330000` lanes.
- **Misaligned write:** sw to `0x101` gives `ram_we`=`4'b0000`, `sl_data_ok` still at T+3, and memory unchanged on readback.
- **Wait states**, `WAIT_CYCLES`=5: read accepted at T gives `sl_data_ok` exactly at T+8. `sl_addr_ok` is low during T+1..T+7.
- **Back-to-back:** `sl_req` held with a new request ready in RESP. `sl_data_ok` and `sl_addr_ok` are both high in that cycle, and the second transaction's `ram_en` follows in the next cycle.
- **Reset in WAIT:** assert `areset` during WAIT. No `sl_data_ok` appears, all outputs go to 0 and `sl_addr_ok` goes to 1 after release. The next read completes normally.
